// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the matrix-keypad scanner.
package keypad_pkg;

  // Widest keypad the scanner supports; helpers operate on this width.
  localparam int MAX_ROWS = 8;

  // Row pattern with no key pressed (rows are active-low).
  localparam logic [MAX_ROWS-1:0] ROWS_IDLE = '1;

  // Scanner FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_PUSH     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  // Linear key code of the key at (row_idx, col_idx).
  function automatic int code_of(input int row_idx, input int col_idx, input int cols);
    return row_idx * cols + col_idx;
  endfunction

  // Index of the lowest 0 bit; when several rows are low the lowest row wins.
  function automatic int lowest_zero_idx(input logic [MAX_ROWS-1:0] pattern);
    int idx;
    idx = 0;
    for (int i = MAX_ROWS - 1; i >= 0; i--) begin
      if (!pattern[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// keypad_code_fifo: small synchronous FIFO holding encoded key codes.
// A count register tells full from empty; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module keypad_code_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array: written at the tail on every accepted push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: drives active-low columns, samples synchronised active-low
// rows once per column dwell, debounces press and release, and queues the
// encoded key code (row_idx*COLS + col_idx) in a small valid/ready FIFO.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int CODE_W    = $clog2(ROWS * COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic              key_held,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int CI_W  = $clog2(COLS);
  localparam int DW_W  = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int FA_W  = $clog2(FIFO_DEPTH);

  localparam logic [ROWS-1:0]  ROW_ALL1   = ROWS_IDLE[ROWS-1:0];
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [CI_W-1:0]  COL_LAST   = CI_W'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_DONE   = CNT_W'(DEBOUNCE);

  logic [ROWS-1:0]   r_sync1;
  logic [ROWS-1:0]   r_sync2;
  state_t            r_state;
  state_t            w_state_next;
  logic [CI_W-1:0]   r_col_idx;
  logic [CI_W-1:0]   w_col_idx_next;
  logic [DW_W-1:0]   r_dwell;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [ROWS-1:0]   r_pattern;
  logic [ROWS-1:0]   w_pattern_next;
  logic [COLS-1:0]   r_col;
  logic [COLS-1:0]   w_col_next;
  logic              r_overflow;
  logic [ROWS-1:0]   w_rs;
  logic              w_sample;
  logic              w_cnt_done;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [MAX_ROWS-1:0] w_pat8;
  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] w_fifo_rdata;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FA_W:0]     w_fifo_count;

  assign w_rs       = r_sync2;
  assign w_sample   = (r_dwell == DWELL_LAST);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_cnt_done = (w_cnt_inc == CNT_DONE);
  assign w_push     = (r_state == ST_PUSH);
  assign valid      = (w_fifo_count != '0);
  assign w_pop      = valid && ready;
  assign w_drop     = w_push && w_fifo_full && !w_pop;
  assign code       = w_fifo_empty ? '0 : w_fifo_rdata;
  assign col        = r_col;
  assign key_held   = (r_state == ST_PUSH) || (r_state == ST_RELEASE);
  assign overflow   = r_overflow;

  // Two-flop synchroniser for the asynchronous rows; idles at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= row;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic: scan columns, debounce the press, push once, await release.
  always_comb begin
    w_state_next   = r_state;
    w_col_idx_next = r_col_idx;
    w_cnt_next     = r_cnt;
    w_pattern_next = r_pattern;
    if (!enable) begin
      w_state_next   = ST_IDLE;
      w_col_idx_next = '0;
      w_cnt_next     = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_col_idx_next = '0;
          w_cnt_next     = '0;
          if (w_rs != ROW_ALL1) w_state_next = ST_SCAN;
        end
        ST_SCAN: begin
          if (w_sample) begin
            if (w_rs != ROW_ALL1) begin
              w_pattern_next = w_rs;
              w_cnt_next     = CNT_W'(1);
              w_state_next   = (DEBOUNCE == 1) ? ST_PUSH : ST_DEBOUNCE;
            end else if (r_col_idx == COL_LAST) begin
              w_state_next   = ST_IDLE;
              w_col_idx_next = '0;
            end else begin
              w_col_idx_next = r_col_idx + 1'b1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (w_sample) begin
            if (w_rs == ROW_ALL1) begin
              w_state_next   = ST_IDLE;
              w_col_idx_next = '0;
              w_cnt_next     = '0;
            end else if (w_rs == r_pattern) begin
              w_cnt_next = w_cnt_inc;
              if (w_cnt_done) w_state_next = ST_PUSH;
            end else begin
              w_pattern_next = w_rs;
              w_cnt_next     = CNT_W'(1);
            end
          end
        end
        ST_PUSH: begin
          w_state_next = ST_RELEASE;
          w_cnt_next   = '0;
        end
        ST_RELEASE: begin
          if (w_sample) begin
            if (w_rs == ROW_ALL1) begin
              if (w_cnt_done) begin
                w_state_next   = ST_IDLE;
                w_col_idx_next = '0;
                w_cnt_next     = '0;
              end else begin
                w_cnt_next = w_cnt_inc;
              end
            end else begin
              w_cnt_next = '0;
            end
          end
        end
        default: begin
          w_state_next   = ST_IDLE;
          w_col_idx_next = '0;
          w_cnt_next     = '0;
        end
      endcase
    end
  end

  // Column drive for the coming cycle: all low in IDLE, one low while scanning, all high when disabled.
  always_comb begin
    w_col_next = '1;
    if (enable) begin
      if (w_state_next == ST_IDLE) w_col_next = '0;
      else                         w_col_next[w_col_idx_next] = 1'b0;
    end
  end

  // FSM state, current column, debounce counter, latched pattern and column drive.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_col_idx <= '0;
      r_cnt     <= '0;
      r_pattern <= ROW_ALL1;
      r_col     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_col_idx <= w_col_idx_next;
      r_cnt     <= w_cnt_next;
      r_pattern <= w_pattern_next;
      r_col     <= w_col_next;
    end
  end

  // Dwell counter restarts on every column change and state entry, and wraps after each sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dwell <= '0;
    end else if ((r_state == ST_IDLE) || (w_state_next != r_state) ||
                 (w_col_idx_next != r_col_idx) || w_sample) begin
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  // Encode the latched pattern: lowest active row wins when several are low.
  always_comb begin
    w_pat8             = ROWS_IDLE;
    w_pat8[ROWS-1:0]   = r_pattern;
    w_code             = CODE_W'(code_of(lowest_zero_idx(w_pat8), int'(r_col_idx), COLS));
  end

  // Sticky overflow: a dropped press sets it, and setting wins over a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (clr_ovf) r_overflow <= 1'b0;
  end

  keypad_code_fifo #(
    .WIDTH(CODE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_code),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo: scenario tasks with a keypad model and a queue of expected codes.
module tb_keypad_scan_fifo;

  logic clockSig = 1'b0;
  logic resetN;

  // Default-parameter instance (4x4, DEBOUNCE=4).
  logic        enableA, readyA, clrOvfA;
  logic [3:0]  rowA, colA, codeA;
  logic        validA, keyHeldA, overflowA;
  logic [15:0] keysA;

  // Variant instance (8 rows x 3 cols, DEBOUNCE=1).
  logic        enableB, readyB, clrOvfB;
  logic [7:0]  rowB;
  logic [2:0]  colB;
  logic [4:0]  codeB;
  logic        validB, keyHeldB, overflowB;
  logic [23:0] keysB;

  int numCompared = 0;
  int numMismatched = 0;
  int expQ[$];
  int expQB[$];

  keypad_scan_fifo dutA (
    .clock(clockSig), .reset(resetN), .enable(enableA), .row(rowA), .col(colA),
    .code(codeA), .valid(validA), .ready(readyA), .key_held(keyHeldA),
    .overflow(overflowA), .clr_ovf(clrOvfA)
  );

  keypad_scan_fifo #(.ROWS(8), .COLS(3), .SCAN_DIV(16), .DEBOUNCE(1), .FIFO_DEPTH(4)) dutB (
    .clock(clockSig), .reset(resetN), .enable(enableB), .row(rowB), .col(colB),
    .code(codeB), .valid(validB), .ready(readyB), .key_held(keyHeldB),
    .overflow(overflowB), .clr_ovf(clrOvfB)
  );

  // Free-running clock shared by both instances.
  always #5 clockSig = ~clockSig;

  // Keypad model for instance A: a pressed key pulls its row low while its column is driven.
  always_comb begin
    rowA = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keysA[r*4+c] && !colA[c]) rowA[r] = 1'b0;
  end

  // Keypad model for instance B.
  always_comb begin
    rowB = '1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 3; c++)
        if (keysB[r*3+c] && !colB[c]) rowB[r] = 1'b0;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clockSig);
  endtask

  // Press a key on A, wait for key_held, release, wait for key_held to drop; ok=0 on timeout.
  task automatic pressReleaseA(input int r, input int c, output bit ok);
    int n;
    ok = 1'b1;
    keysA[r*4+c] = 1'b1;
    n = 0;
    while (keyHeldA !== 1'b1 && n < 400) begin @(negedge clockSig); n++; end
    if (keyHeldA !== 1'b1) ok = 1'b0;
    keysA[r*4+c] = 1'b0;
    n = 0;
    while (keyHeldA !== 1'b0 && n < 400) begin @(negedge clockSig); n++; end
    if (keyHeldA !== 1'b0) ok = 1'b0;
    waitCycles(5);
  endtask

  task automatic test_reset;
    $display("[TB] test_reset");
    waitCycles(2);
    numCompared++; if (colA !== 4'h0) begin numMismatched++; $display("[TB] FAIL reset_col: got %h, expected 0", colA); end
    numCompared++; if (validA !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_valid: got %b, expected 0", validA); end
    numCompared++; if (codeA !== 4'h0) begin numMismatched++; $display("[TB] FAIL reset_code: got %0d, expected 0", codeA); end
    numCompared++; if (keyHeldA !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_key_held: got %b, expected 0", keyHeldA); end
    numCompared++; if (overflowA !== 1'b0) begin numMismatched++; $display("[TB] FAIL reset_overflow: got %b, expected 0", overflowA); end
    resetN = 1'b1;
    waitCycles(3);
    numCompared++; if (colA !== 4'h0) begin numMismatched++; $display("[TB] FAIL idle_col: got %h, expected 0", colA); end
    numCompared++; if (colB !== 3'h0) begin numMismatched++; $display("[TB] FAIL idle_colB: got %h, expected 0", colB); end
  endtask

  task automatic test_single_press;
    int guard, expCode;
    $display("[TB] test_single_press");
    readyA = 1'b0;
    expQ.push_back(1*4 + 2);
    keysA[1*4+2] = 1'b1;
    waitCycles(98);
    numCompared++; if (keyHeldA !== 1'b0) begin numMismatched++; $display("[TB] FAIL early_push: key_held got %b, expected 0", keyHeldA); end
    waitCycles(1);
    numCompared++; if (keyHeldA !== 1'b1) begin numMismatched++; $display("[TB] FAIL push_cycle: key_held got %b, expected 1", keyHeldA); end
    numCompared++; if (validA !== 1'b0) begin numMismatched++; $display("[TB] FAIL valid_early: got %b, expected 0", validA); end
    waitCycles(1);
    numCompared++; if (validA !== 1'b1) begin numMismatched++; $display("[TB] FAIL valid_latency: got %b, expected 1", validA); end
    waitCycles(100);
    keysA[1*4+2] = 1'b0;
    waitCycles(48);
    numCompared++; if (keyHeldA !== 1'b1) begin numMismatched++; $display("[TB] FAIL release_early: key_held got %b, expected 1", keyHeldA); end
    guard = 0;
    while (keyHeldA !== 1'b0 && guard < 40) begin @(negedge clockSig); guard++; end
    numCompared++; if (keyHeldA !== 1'b0) begin numMismatched++; $display("[TB] FAIL release_timeout: key_held got %b, expected 0", keyHeldA); end
    waitCycles(20);
    readyA = 1'b1;
    guard = 0;
    while (expQ.size() > 0 && guard < 50) begin
      if (validA === 1'b1) begin
        expCode = expQ.pop_front();
        numCompared++; if (codeA !== expCode[3:0]) begin numMismatched++; $display("[TB] FAIL drain_code: got %0d, expected %0d", codeA, expCode); end
      end
      guard++;
      @(negedge clockSig);
    end
    readyA = 1'b0;
    numCompared++; if (expQ.size() != 0) begin numMismatched++; $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size()); expQ.delete(); end
    numCompared++; if (validA !== 1'b0) begin numMismatched++; $display("[TB] FAIL single_event: valid got %b, expected 0", validA); end
  endtask

  task automatic test_glitch;
    $display("[TB] test_glitch");
    keysA[0*4+1] = 1'b1;
    waitCycles(1);
    keysA[0*4+1] = 1'b0;
    waitCycles(9);
    numCompared++; if (colA !== 4'b1110) begin numMismatched++; $display("[TB] FAIL glitch_scan_col: got %b, expected 1110", colA); end
    waitCycles(100);
    numCompared++; if (colA !== 4'h0) begin numMismatched++; $display("[TB] FAIL glitch1_idle_col: got %b, expected 0000", colA); end
    numCompared++; if (validA !== 1'b0) begin numMismatched++; $display("[TB] FAIL glitch1_valid: got %b, expected 0", validA); end
    keysA[2*4+1] = 1'b1;
    waitCycles(20);
    keysA[2*4+1] = 1'b0;
    waitCycles(150);
    numCompared++; if (colA !== 4'h0) begin numMismatched++; $display("[TB] FAIL glitch20_idle_col: got %b, expected 0000", colA); end
    numCompared++; if (validA !== 1'b0 || keyHeldA !== 1'b0) begin numMismatched++; $display("[TB] FAIL glitch20_event: valid/key_held got %b%b, expected 00", validA, keyHeldA); end
  endtask

  task automatic test_overflow;
    int codes[5] = '{0, 5, 10, 15, 3};
    int guard, expCode;
    bit ok;
    $display("[TB] test_overflow");
    readyA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expQ.push_back(codes[i]);
      if (i == 4) begin
        numCompared++; if (overflowA !== 1'b0) begin numMismatched++; $display("[TB] FAIL overflow_early: got %b, expected 0", overflowA); end
      end
      pressReleaseA(codes[i] / 4, codes[i] % 4, ok);
      numCompared++; if (!ok) begin numMismatched++; $display("[TB] FAIL press_timeout: code %0d got no press/release, expected both", codes[i]); end
    end
    numCompared++; if (overflowA !== 1'b1) begin numMismatched++; $display("[TB] FAIL overflow_set: got %b, expected 1", overflowA); end
    readyA = 1'b1;
    guard = 0;
    while (expQ.size() > 0 && guard < 50) begin
      if (validA === 1'b1) begin
        expCode = expQ.pop_front();
        numCompared++; if (codeA !== expCode[3:0]) begin numMismatched++; $display("[TB] FAIL drain_order: got %0d, expected %0d", codeA, expCode); end
      end
      guard++;
      @(negedge clockSig);
    end
    readyA = 1'b0;
    numCompared++; if (expQ.size() != 0) begin numMismatched++; $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size()); expQ.delete(); end
    numCompared++; if (validA !== 1'b0) begin numMismatched++; $display("[TB] FAIL dropped_code_present: valid got %b, expected 0", validA); end
    clrOvfA = 1'b1;
    waitCycles(1);
    clrOvfA = 1'b0;
    numCompared++; if (overflowA !== 1'b0) begin numMismatched++; $display("[TB] FAIL overflow_clear: got %b, expected 0", overflowA); end
  endtask

  task automatic test_multi_key;
    int guard, expCode;
    $display("[TB] test_multi_key");
    readyA = 1'b0;
    expQ.push_back(4);
    keysA[1*4+0] = 1'b1;
    keysA[3*4+0] = 1'b1;
    guard = 0;
    while (keyHeldA !== 1'b1 && guard < 400) begin @(negedge clockSig); guard++; end
    numCompared++; if (keyHeldA !== 1'b1) begin numMismatched++; $display("[TB] FAIL multi_press: key_held got %b, expected 1", keyHeldA); end
    keysA[2*4+0] = 1'b1;
    keysA[0*4+2] = 1'b1;
    waitCycles(100);
    numCompared++; if (keyHeldA !== 1'b1) begin numMismatched++; $display("[TB] FAIL held_second_key: key_held got %b, expected 1", keyHeldA); end
    keysA = '0;
    guard = 0;
    while (keyHeldA !== 1'b0 && guard < 400) begin @(negedge clockSig); guard++; end
    numCompared++; if (keyHeldA !== 1'b0) begin numMismatched++; $display("[TB] FAIL multi_release: key_held got %b, expected 0", keyHeldA); end
    waitCycles(100);
    readyA = 1'b1;
    guard = 0;
    while (expQ.size() > 0 && guard < 50) begin
      if (validA === 1'b1) begin
        expCode = expQ.pop_front();
        numCompared++; if (codeA !== expCode[3:0]) begin numMismatched++; $display("[TB] FAIL multi_code: got %0d, expected %0d", codeA, expCode); end
      end
      guard++;
      @(negedge clockSig);
    end
    readyA = 1'b0;
    numCompared++; if (expQ.size() != 0) begin numMismatched++; $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size()); expQ.delete(); end
    numCompared++; if (validA !== 1'b0) begin numMismatched++; $display("[TB] FAIL extra_event: valid got %b, expected 0", validA); end
  endtask

  task automatic test_param_variant;
    int guard, expCode;
    $display("[TB] test_param_variant");
    readyB = 1'b0;
    expQB.push_back(7*3 + 1);
    keysB[7*3+1] = 1'b1;
    waitCycles(34);
    numCompared++; if (keyHeldB !== 1'b0) begin numMismatched++; $display("[TB] FAIL b_early_push: key_held got %b, expected 0", keyHeldB); end
    waitCycles(1);
    numCompared++; if (keyHeldB !== 1'b1 || validB !== 1'b0) begin numMismatched++; $display("[TB] FAIL b_push_cycle: key_held/valid got %b%b, expected 10", keyHeldB, validB); end
    waitCycles(1);
    numCompared++; if (validB !== 1'b1) begin numMismatched++; $display("[TB] FAIL b_valid_latency: got %b, expected 1", validB); end
    keysB[7*3+1] = 1'b0;
    guard = 0;
    while (keyHeldB !== 1'b0 && guard < 100) begin @(negedge clockSig); guard++; end
    numCompared++; if (keyHeldB !== 1'b0) begin numMismatched++; $display("[TB] FAIL b_release: key_held got %b, expected 0", keyHeldB); end
    readyB = 1'b1;
    guard = 0;
    while (expQB.size() > 0 && guard < 50) begin
      if (validB === 1'b1) begin
        expCode = expQB.pop_front();
        numCompared++; if (codeB !== expCode[4:0]) begin numMismatched++; $display("[TB] FAIL b_code: got %0d, expected %0d", codeB, expCode); end
      end
      guard++;
      @(negedge clockSig);
    end
    readyB = 1'b0;
    numCompared++; if (expQB.size() != 0) begin numMismatched++; $display("[TB] FAIL b_drain_timeout: got %0d pending, expected 0", expQB.size()); expQB.delete(); end
    numCompared++; if (validB !== 1'b0) begin numMismatched++; $display("[TB] FAIL b_extra_event: valid got %b, expected 0", validB); end
  endtask

  task automatic test_reset_mid_press;
    $display("[TB] test_reset_mid_press");
    keysA[0] = 1'b1;
    waitCycles(27);
    numCompared++; if (colA !== 4'b1110) begin numMismatched++; $display("[TB] FAIL debounce_col: got %b, expected 1110", colA); end
    #2 resetN = 1'b0;
    #1;
    numCompared++; if (colA !== 4'h0 || keyHeldA !== 1'b0 || validA !== 1'b0 || codeA !== 4'h0) begin
      numMismatched++; $display("[TB] FAIL async_reset: col/key_held/valid/code got %b/%b/%b/%0d, expected 0000/0/0/0", colA, keyHeldA, validA, codeA);
    end
    keysA[0] = 1'b0;
    waitCycles(2);
    resetN = 1'b1;
    waitCycles(150);
    numCompared++; if (validA !== 1'b0) begin numMismatched++; $display("[TB] FAIL partial_code: valid got %b, expected 0", validA); end
  endtask

  task automatic test_enable;
    int guard, expCode;
    bit ok;
    $display("[TB] test_enable");
    readyA = 1'b0;
    expQ.push_back(1*4 + 1);
    pressReleaseA(1, 1, ok);
    numCompared++; if (!ok) begin numMismatched++; $display("[TB] FAIL en_press_timeout: got no press/release, expected both"); end
    keysA[2*4+3] = 1'b1;
    waitCycles(10);
    numCompared++; if (colA !== 4'b1110) begin numMismatched++; $display("[TB] FAIL en_scan_col: got %b, expected 1110", colA); end
    enableA = 1'b0;
    waitCycles(1);
    numCompared++; if (colA !== 4'b1111 || keyHeldA !== 1'b0) begin numMismatched++; $display("[TB] FAIL disable: col/key_held got %b/%b, expected 1111/0", colA, keyHeldA); end
    readyA = 1'b1;
    guard = 0;
    while (expQ.size() > 0 && guard < 50) begin
      if (validA === 1'b1) begin
        expCode = expQ.pop_front();
        numCompared++; if (codeA !== expCode[3:0]) begin numMismatched++; $display("[TB] FAIL disabled_pop: got %0d, expected %0d", codeA, expCode); end
      end
      guard++;
      @(negedge clockSig);
    end
    readyA = 1'b0;
    numCompared++; if (expQ.size() != 0) begin numMismatched++; $display("[TB] FAIL disabled_drain_timeout: got %0d pending, expected 0", expQ.size()); expQ.delete(); end
    keysA[2*4+3] = 1'b0;
    waitCycles(5);
    enableA = 1'b1;
    waitCycles(3);
    numCompared++; if (colA !== 4'h0) begin numMismatched++; $display("[TB] FAIL reenable_idle: col got %b, expected 0000", colA); end
    waitCycles(150);
    numCompared++; if (validA !== 1'b0) begin numMismatched++; $display("[TB] FAIL reenable_event: valid got %b, expected 0", validA); end
  endtask

  // Safety net so the run always ends even if a wait loop misbehaves.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    resetN  = 1'b0;
    enableA = 1'b1; readyA = 1'b0; clrOvfA = 1'b0; keysA = '0;
    enableB = 1'b1; readyB = 1'b0; clrOvfB = 1'b0; keysB = '0;
    test_reset();
    test_single_press();
    test_glitch();
    test_overflow();
    test_multi_key();
    test_param_variant();
    test_reset_mid_press();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
